// File: rtl/alu_exec_if.sv
// Execute-stage bus: decoded controls and operands in, ALU result/flags and
// the registered EX/MEM bundle out.
interface alu_exec_if #(
   parameter int DATA_W = 64
);
   logic [1:0]        alu_op;
   logic [10:0]       opcode;
   logic [DATA_W-1:0] a;
   logic [DATA_W-1:0] b;
   logic [2:0]        mem_in;
   logic [1:0]        wb_in;
   logic [DATA_W-1:0] br_addr_in;
   logic [DATA_W-1:0] store_data_in;
   logic [4:0]        rw_in;

   logic [DATA_W-1:0] alu_result;
   logic              neg;
   logic              zero;
   logic              ovf;
   logic              cout;

   logic [DATA_W-1:0] alu_result_q;
   logic [DATA_W-1:0] br_addr_q;
   logic [DATA_W-1:0] store_data_q;
   logic [2:0]        mem_q;
   logic [1:0]        wb_q;
   logic [4:0]        rw_q;
   logic              neg_q;
   logic              zero_q;
   logic              ovf_q;
   logic              cout_q;

   logic              flag_n;
   logic              flag_z;
   logic              flag_v;
   logic              flag_c;

   modport master (
      output alu_op, opcode, a, b, mem_in, wb_in, br_addr_in, store_data_in, rw_in,
      input  alu_result, neg, zero, ovf, cout,
      input  alu_result_q, br_addr_q, store_data_q, mem_q, wb_q, rw_q,
      input  neg_q, zero_q, ovf_q, cout_q,
      input  flag_n, flag_z, flag_v, flag_c
   );

   modport slave (
      input  alu_op, opcode, a, b, mem_in, wb_in, br_addr_in, store_data_in, rw_in,
      output alu_result, neg, zero, ovf, cout,
      output alu_result_q, br_addr_q, store_data_q, mem_q, wb_q, rw_q,
      output neg_q, zero_q, ovf_q, cout_q,
      output flag_n, flag_z, flag_v, flag_c
   );
endinterface

// File: rtl/alu_exec_stage.sv
// Execute stage: ALU control decode, combinational ALU with NZVC flags,
// EX/MEM pipeline register and the architectural condition flags.
module alu_exec_stage #(
   parameter int DATA_W = 64
) (
   input logic     clk,
   input logic     reset,
   alu_exec_if.slave bus
);
   localparam logic [2:0] CTL_PASS = 3'b000;
   localparam logic [2:0] CTL_ADD  = 3'b010;
   localparam logic [2:0] CTL_SUB  = 3'b011;
   localparam logic [2:0] CTL_AND  = 3'b100;
   localparam logic [2:0] CTL_OR   = 3'b101;
   localparam logic [2:0] CTL_XOR  = 3'b110;

   localparam logic [10:0] OP_ADD  = 11'b10001011000;
   localparam logic [10:0] OP_ADDS = 11'b10101011000;
   localparam logic [10:0] OP_SUB  = 11'b11001011000;
   localparam logic [10:0] OP_SUBS = 11'b11101011000;
   localparam logic [10:0] OP_AND  = 11'b10001010000;
   localparam logic [10:0] OP_ORR  = 11'b10101010000;
   localparam logic [10:0] OP_EOR  = 11'b11001010000;
   localparam logic [9:0]  OP_ADDI = 10'b1001000100;

   logic [2:0]        ctl;
   logic              is_sub;
   logic              is_arith;
   logic [DATA_W-1:0] b_op;
   logic [DATA_W:0]   sum;
   logic [DATA_W-1:0] result;
   logic              set_flags;

   always_comb begin
      ctl = CTL_PASS;
      case (bus.alu_op)
         2'b00: ctl = CTL_ADD;
         2'b10: begin
            case (bus.opcode)
               OP_ADD, OP_ADDS: ctl = CTL_ADD;
               OP_SUB, OP_SUBS: ctl = CTL_SUB;
               OP_AND:          ctl = CTL_AND;
               OP_ORR:          ctl = CTL_OR;
               OP_EOR:          ctl = CTL_XOR;
               default:         ctl = (bus.opcode[10:1] == OP_ADDI) ? CTL_ADD : CTL_PASS;
            endcase
         end
         default: ctl = CTL_PASS;
      endcase
   end

   // Subtraction reuses the adder as a + ~b + 1, so cout reads as "no borrow".
   assign is_sub   = (ctl == CTL_SUB);
   assign is_arith = (ctl == CTL_ADD) || is_sub;
   assign b_op     = is_sub ? ~bus.b : bus.b;
   assign sum      = {1'b0, bus.a} + {1'b0, b_op} + {{DATA_W{1'b0}}, is_sub};

   always_comb begin
      result = '0;
      case (ctl)
         CTL_PASS:         result = bus.b;
         CTL_ADD, CTL_SUB: result = sum[DATA_W-1:0];
         CTL_AND:          result = bus.a & bus.b;
         CTL_OR:           result = bus.a | bus.b;
         CTL_XOR:          result = bus.a ^ bus.b;
         default:          result = '0;
      endcase
   end

   assign bus.alu_result = result;
   assign bus.neg        = result[DATA_W-1];
   assign bus.zero       = (result == '0);
   assign bus.cout       = is_arith & sum[DATA_W];
   assign bus.ovf        = is_arith & (bus.a[DATA_W-1] == b_op[DATA_W-1])
                                    & (result[DATA_W-1] != bus.a[DATA_W-1]);

   assign set_flags = (bus.opcode == OP_ADDS) || (bus.opcode == OP_SUBS);

   always_ff @(posedge clk) begin
      if (reset) begin
         bus.alu_result_q <= '0;
         bus.br_addr_q    <= '0;
         bus.store_data_q <= '0;
         bus.mem_q        <= '0;
         bus.wb_q         <= '0;
         bus.rw_q         <= '0;
         bus.neg_q        <= 1'b0;
         bus.zero_q       <= 1'b0;
         bus.ovf_q        <= 1'b0;
         bus.cout_q       <= 1'b0;
         bus.flag_n       <= 1'b0;
         bus.flag_z       <= 1'b0;
         bus.flag_v       <= 1'b0;
         bus.flag_c       <= 1'b0;
      end else begin
         bus.alu_result_q <= result;
         bus.br_addr_q    <= bus.br_addr_in;
         bus.store_data_q <= bus.store_data_in;
         bus.mem_q        <= bus.mem_in;
         bus.wb_q         <= bus.wb_in;
         bus.rw_q         <= bus.rw_in;
         bus.neg_q        <= bus.neg;
         bus.zero_q       <= bus.zero;
         bus.ovf_q        <= bus.ovf;
         bus.cout_q       <= bus.cout;
         if (set_flags) begin
            bus.flag_n <= bus.neg;
            bus.flag_z <= bus.zero;
            bus.flag_v <= bus.ovf;
            bus.flag_c <= bus.cout;
         end
      end
   end
endmodule

// File: tb/tb_alu_exec_stage.sv
// Table-driven bench for alu_exec_stage plus directed flag-hold and reset sequences.
module tb_alu_exec_stage;
   typedef struct {
      string       name;
      logic [1:0]  alu_op;
      logic [10:0] opcode;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] res;
      logic [3:0]  nzvc;
   } vec_t;

   localparam logic [10:0] ADD  = 11'b10001011000;
   localparam logic [10:0] ADDS = 11'b10101011000;
   localparam logic [10:0] SUB  = 11'b11001011000;
   localparam logic [10:0] SUBS = 11'b11101011000;
   localparam logic [10:0] ANDO = 11'b10001010000;
   localparam logic [10:0] ORR  = 11'b10101010000;
   localparam logic [10:0] EOR  = 11'b11001010000;
   localparam logic [10:0] ADDI = 11'b10010001000;
   localparam logic [10:0] LDUR = 11'b11111000010;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   passed = 0;
   int   total = 0;

   alu_exec_if #(.DATA_W(64)) bus ();

   alu_exec_stage #(.DATA_W(64)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   vec_t vecs[14];
   logic [3:0]  flags_exp;
   logic [2:0]  mem_v;
   logic [1:0]  wb_v;
   logic [4:0]  rw_v;
   logic [63:0] br_v;
   logic [63:0] st_v;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
   endtask

   function automatic vec_t mk(input string n, input logic [1:0] op, input logic [10:0] opc,
                               input logic [63:0] a, input logic [63:0] b,
                               input logic [63:0] r, input logic [3:0] f);
      vec_t v;
      v.name = n; v.alu_op = op; v.opcode = opc; v.a = a; v.b = b; v.res = r; v.nzvc = f;
      return v;
   endfunction

   task automatic drive(input logic [1:0] op, input logic [10:0] opc,
                        input logic [63:0] a, input logic [63:0] b);
      bus.alu_op = op; bus.opcode = opc; bus.a = a; bus.b = b;
      bus.mem_in = mem_v; bus.wb_in = wb_v; bus.rw_in = rw_v;
      bus.br_addr_in = br_v; bus.store_data_in = st_v;
   endtask

   task automatic check_flags(input string name, input logic [3:0] exp);
      check({name, ".flags"}, {60'd0, bus.flag_n, bus.flag_z, bus.flag_v, bus.flag_c}, {60'd0, exp});
   endtask

   task automatic check_q_zero(input string name);
      check({name, ".res_q"}, bus.alu_result_q, 64'd0);
      check({name, ".br_q"}, bus.br_addr_q, 64'd0);
      check({name, ".st_q"}, bus.store_data_q, 64'd0);
      check({name, ".ctl_q"}, {54'd0, bus.mem_q, bus.wb_q, bus.rw_q}, 64'd0);
      check({name, ".nzvc_q"}, {60'd0, bus.neg_q, bus.zero_q, bus.ovf_q, bus.cout_q}, 64'd0);
      check_flags(name, 4'b0000);
   endtask

   initial begin
      vecs[0]  = mk("adds_ovf",  2'b10, ADDS, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,
                    64'h8000_0000_0000_0000, 4'b1010);
      vecs[1]  = mk("subs_eq",   2'b10, SUBS, 64'd5, 64'd5, 64'd0, 4'b0101);
      vecs[2]  = mk("cbz",       2'b01, LDUR, 64'h1234, 64'd0, 64'd0, 4'b0100);
      vecs[3]  = mk("ldst_add",  2'b00, LDUR, 64'h100, 64'h8, 64'h108, 4'b0000);
      vecs[4]  = mk("and",       2'b10, ANDO, 64'hF0F0, 64'hFF00, 64'hF000, 4'b0000);
      vecs[5]  = mk("orr",       2'b10, ORR,  64'hF0F0, 64'hFF00, 64'hFFF0, 4'b0000);
      vecs[6]  = mk("eor",       2'b10, EOR,  64'hF0F0, 64'hFF00, 64'h0FF0, 4'b0000);
      vecs[7]  = mk("sub_borrow", 2'b10, SUB, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000);
      vecs[8]  = mk("add_wrap",  2'b10, ADD,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'b0101);
      vecs[9]  = mk("addi",      2'b10, ADDI, 64'd10, 64'd20, 64'd30, 4'b0000);
      vecs[10] = mk("pass_shift", 2'b11, ADDS, 64'd5, 64'hDEAD, 64'hDEAD, 4'b0000);
      vecs[11] = mk("unknown_op", 2'b10, LDUR, 64'd9, 64'h77, 64'h77, 4'b0000);
      vecs[12] = mk("subs_ovf",  2'b10, SUBS, 64'h8000_0000_0000_0000, 64'd1,
                    64'h7FFF_FFFF_FFFF_FFFF, 4'b0011);
      vecs[13] = mk("add_negneg", 2'b00, SUB, 64'h8000_0000_0000_0000,
                    64'h8000_0000_0000_0000, 64'd0, 4'b0111);

      mem_v = 3'd0; wb_v = 2'd0; rw_v = 5'd0; br_v = 64'd0; st_v = 64'd0;
      drive(2'b00, LDUR, 64'd0, 64'd0);
      repeat (2) @(posedge clk);
      #1;
      check_q_zero("reset_state");
      reset = 1'b0;
      flags_exp = 4'b0000;

      for (int i = 0; i < 14; i++) begin
         mem_v = 3'(i + 1); wb_v = 2'(i + 2); rw_v = 5'(i * 3 + 1);
         br_v = 64'h4000 + 64'(i) * 64'h10; st_v = ~vecs[i].a;
         drive(vecs[i].alu_op, vecs[i].opcode, vecs[i].a, vecs[i].b);
         #1;
         check({vecs[i].name, ".res"}, bus.alu_result, vecs[i].res);
         check({vecs[i].name, ".nzvc"}, {60'd0, bus.neg, bus.zero, bus.ovf, bus.cout},
               {60'd0, vecs[i].nzvc});
         if (vecs[i].opcode == ADDS || vecs[i].opcode == SUBS) flags_exp = vecs[i].nzvc;
         @(posedge clk);
         #1;
         check({vecs[i].name, ".res_q"}, bus.alu_result_q, vecs[i].res);
         check({vecs[i].name, ".nzvc_q"}, {60'd0, bus.neg_q, bus.zero_q, bus.ovf_q, bus.cout_q},
               {60'd0, vecs[i].nzvc});
         check({vecs[i].name, ".br_q"}, bus.br_addr_q, br_v);
         check({vecs[i].name, ".st_q"}, bus.store_data_q, st_v);
         check({vecs[i].name, ".ctl_q"}, {54'd0, bus.mem_q, bus.wb_q, bus.rw_q},
               {54'd0, mem_v, wb_v, rw_v});
         check_flags(vecs[i].name, flags_exp);
         $display("vec %0d %s: res=0x%016h flags=%b", i, vecs[i].name, bus.alu_result,
                  {bus.flag_n, bus.flag_z, bus.flag_v, bus.flag_c});
      end

      // SUBS sets flags, then a non-setting ADD with different NZVC must leave them alone.
      drive(2'b10, SUBS, 64'd2, 64'd7);
      @(posedge clk);
      #1;
      check_flags("subs_neg", 4'b1000);
      drive(2'b10, ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
      @(posedge clk);
      #1;
      check_flags("hold_after_add", 4'b1000);
      check("hold_after_add.zero_q", {63'd0, bus.zero_q}, 64'd1);
      $display("seq flag_hold: flags=%b", {bus.flag_n, bus.flag_z, bus.flag_v, bus.flag_c});

      // Mid-stream reset: in-flight bundle discarded, combinational path untouched.
      mem_v = 3'b111; wb_v = 2'b11; rw_v = 5'd31; br_v = 64'hAAAA; st_v = 64'h5555;
      drive(2'b10, ADDS, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
      @(posedge clk);
      #1;
      check_flags("pre_reset", 4'b1010);
      mem_v = 3'b101; wb_v = 2'b10; rw_v = 5'd7; br_v = 64'hBEEF; st_v = 64'hCAFE;
      drive(2'b00, LDUR, 64'h100, 64'h8);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check_q_zero("mid_reset");
      check("mid_reset.comb_res", bus.alu_result, 64'h108);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("post_reset.res_q", bus.alu_result_q, 64'h108);
      check("post_reset.br_q", bus.br_addr_q, 64'hBEEF);
      check("post_reset.st_q", bus.store_data_q, 64'hCAFE);
      check("post_reset.ctl_q", {54'd0, bus.mem_q, bus.wb_q, bus.rw_q},
            {54'd0, 3'b101, 2'b10, 5'd7});
      check_flags("post_reset", 4'b0000);
      $display("seq reset: res_q=0x%016h", bus.alu_result_q);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
